// File: rtl/eda_region_stack_pkg.sv
// Shared types and build-time sizing for the region-grow address stack.
// Sizing comes from the CFG_* macros, which default to a 4x4 image with a 3x3 window.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 4
`endif

package eda_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} region_state_e;

    localparam int EDA_M            = `CFG_M;
    localparam int EDA_N            = `CFG_N;
    localparam int EDA_WINDOW_WIDTH = `CFG_WINDOW_WIDTH;
    localparam int EDA_ADDR_WIDTH   = `CFG_ADDR_WIDTH;
    localparam int EDA_DEPTH        = EDA_M * EDA_N;
    localparam int EDA_CNT_WIDTH    = $clog2(EDA_DEPTH + 1);
endpackage

// File: rtl/eda_region_stack_compactor.sv
// Push-mask compactor: total lane count and each lane's exclusive prefix popcount.
// Purely combinational, no state and no backpressure.
module eda_push_compactor #(
    parameter int LANES = 8,
    parameter int OW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]         i_mask,
    output logic [OW-1:0]            o_k,
    output logic [LANES-1:0][OW-1:0] o_lane_off
);
    always_comb begin
        logic [OW-1:0] w_acc;
        w_acc      = '0;
        o_lane_off = '0;
        for (int i = 0; i < LANES; i++) begin
            o_lane_off[i] = w_acc;
            w_acc         = w_acc + OW'(i_mask[i]);
        end
        o_k = w_acc;
    end
endmodule

// File: rtl/eda_region_stack.sv
// LIFO of {i,j} addresses for region grow: compacted multi-lane push, single pop, pop-to-top 0 cycles.
// Full batches that do not fit are dropped whole (sticky overflow); `EDA_STACK_HWM_EN adds the hwm output.
module eda_region_stack
    import eda_pkg::*;
#(
    parameter int M            = EDA_M,
    parameter int N            = EDA_N,
    parameter int WINDOW_WIDTH = EDA_WINDOW_WIDTH,
    parameter int ADDR_WIDTH   = EDA_ADDR_WIDTH,
    parameter int DEPTH        = M * N,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                                    inv_clk,
    input  logic                                    reset_n,
    input  logic                                    clear,
    input  logic [WINDOW_WIDTH-2:0]                 push_mask,
    input  logic [WINDOW_WIDTH-2:0][ADDR_WIDTH-1:0] push_addr_arr,
    input  logic                                    pop,
    output logic [ADDR_WIDTH-1:0]                   top_addr,
    output logic                                    top_valid,
    output logic [CNT_WIDTH-1:0]                    count,
    output logic                                    full,
    output logic                                    region_done,
    output logic                                    overflow,
    output logic                                    underflow
`ifdef EDA_STACK_HWM_EN
    ,
    output logic [CNT_WIDTH-1:0]                    hwm
`endif
);
    localparam int LANES = WINDOW_WIDTH - 1;
    localparam int OW    = $clog2(LANES + 1);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0]   r_mem [DEPTH];
    logic [CNT_WIDTH-1:0]    r_count;
    region_state_e           r_state;
    logic                    r_region_done;
    logic                    r_overflow;
    logic                    r_underflow;

    logic [OW-1:0]            w_k;
    logic [LANES-1:0][OW-1:0] w_off;
    logic                     w_pop_ok;
    logic [CNT_WIDTH-1:0]     w_base;
    logic                     w_fits;
    logic [CNT_WIDTH-1:0]     w_count_next;
    logic [LANES-1:0][IW-1:0] w_wr_idx;

    eda_push_compactor #(.LANES(LANES), .OW(OW)) u_compactor (
        .i_mask     (push_mask),
        .o_k        (w_k),
        .o_lane_off (w_off)
    );

    // Pop is retired before the push batch lands, so a full stack still takes one entry on pop.
    always_comb begin
        w_pop_ok     = pop && (r_count != '0);
        w_base       = r_count - CNT_WIDTH'(w_pop_ok);
        w_fits       = (32'(w_base) + 32'(w_k)) <= 32'(DEPTH);
        w_count_next = w_fits ? (w_base + CNT_WIDTH'(w_k)) : w_base;
        for (int i = 0; i < LANES; i++) begin
            w_wr_idx[i] = IW'(w_base + CNT_WIDTH'(w_off[i]));
        end
    end

    always_ff @(posedge inv_clk) begin
        if (!clear && w_fits) begin
            for (int i = 0; i < LANES; i++) begin
                if (push_mask[i]) r_mem[w_wr_idx[i]] <= push_addr_arr[i];
            end
        end
    end

    always_ff @(posedge inv_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_state       <= ST_IDLE;
            r_region_done <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (clear) begin
            r_count       <= '0;
            r_state       <= ST_IDLE;
            r_region_done <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_region_done <= 1'b0;
            if (pop && r_count == '0) r_underflow <= 1'b1;
            if (!w_fits)              r_overflow  <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_count_next != '0) r_state <= ST_ACTIVE;
                ST_ACTIVE: begin
                    if (w_count_next == '0) begin
                        r_state       <= ST_DONE;
                        r_region_done <= 1'b1;
                    end
                end
                ST_DONE: r_state <= (w_count_next != '0) ? ST_ACTIVE : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef EDA_STACK_HWM_EN
    logic [CNT_WIDTH-1:0] r_hwm;
    always_ff @(posedge inv_clk or negedge reset_n) begin
        if (!reset_n)             r_hwm <= '0;
        else if (clear)           r_hwm <= '0;
        else if (r_count > r_hwm) r_hwm <= r_count;
    end
    assign hwm = r_hwm;
`endif

    assign top_addr    = (r_count == '0) ? '0 : r_mem[IW'(r_count - 1'b1)];
    assign top_valid   = (r_count != '0);
    assign count       = r_count;
    assign full        = (32'(r_count) == 32'(DEPTH));
    assign region_done = r_region_done;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
endmodule

// File: tb/tb_eda_region_stack.sv
// Bench for eda_region_stack: directed table, multi-cycle corner sequences, and random traffic vs a queue model.
module tb_eda_region_stack;
    import eda_pkg::*;

    localparam int DEPTH = EDA_DEPTH;
    localparam int CW    = EDA_CNT_WIDTH;
    localparam int AW    = EDA_ADDR_WIDTH;
    localparam int LN    = EDA_WINDOW_WIDTH - 1;

    logic                   inv_clk = 1'b0;
    logic                   reset_n;
    logic                   clear;
    logic [LN-1:0]          push_mask;
    logic [LN-1:0][AW-1:0]  push_addr_arr;
    logic                   pop;
    logic [AW-1:0]          top_addr;
    logic                   top_valid;
    logic [CW-1:0]          count;
    logic                   full, region_done, overflow, underflow;
`ifdef EDA_STACK_HWM_EN
    logic [CW-1:0]          hwm;
`endif

    eda_region_stack dut (
        .inv_clk       (inv_clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .push_mask     (push_mask),
        .push_addr_arr (push_addr_arr),
        .pop           (pop),
        .top_addr      (top_addr),
        .top_valid     (top_valid),
        .count         (count),
        .full          (full),
        .region_done   (region_done),
        .overflow      (overflow),
        .underflow     (underflow)
`ifdef EDA_STACK_HWM_EN
        ,
        .hwm           (hwm)
`endif
    );

    always #5 inv_clk = ~inv_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Reference model: stack as a queue, back = top
    logic [AW-1:0] mq[$];
    int m_ovf, m_udf, m_done, m_hwm;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_udf = 0; m_done = 0; m_hwm = 0;
    endtask

    task automatic model_step(input logic [LN-1:0] m, input logic [LN*AW-1:0] a,
                              input logic pp, input logic cl);
        int prev, k;
        if (cl) begin
            model_reset();
            return;
        end
        prev = mq.size();
        if (prev > m_hwm) m_hwm = prev;
        if (pp) begin
            if (prev == 0) m_udf = 1;
            else void'(mq.pop_back());
        end
        k = $countones(m);
        if (mq.size() + k > DEPTH) m_ovf = 1;
        else for (int i = 0; i < LN; i++) if (m[i]) mq.push_back(a[i*AW +: AW]);
        m_done = (prev > 0 && mq.size() == 0) ? 1 : 0;
    endtask

    task automatic check_model(input string tag);
        int exp_top;
        exp_top = (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0;
        check({tag, ".count"},       int'(count),       mq.size());
        check({tag, ".top_valid"},   int'(top_valid),   (mq.size() > 0) ? 1 : 0);
        check({tag, ".top_addr"},    int'(top_addr),    exp_top);
        check({tag, ".full"},        int'(full),        (mq.size() == DEPTH) ? 1 : 0);
        check({tag, ".region_done"}, int'(region_done), m_done);
        check({tag, ".overflow"},    int'(overflow),    m_ovf);
        check({tag, ".underflow"},   int'(underflow),   m_udf);
`ifdef EDA_STACK_HWM_EN
        check({tag, ".hwm"},         int'(hwm),         m_hwm);
`endif
    endtask

    // One clock: drive, advance the model, sample #1 after the edge, idle the inputs
    task automatic cyc(input logic [LN-1:0] m, input logic [LN*AW-1:0] a,
                       input logic pp, input logic cl, input string tag);
        push_mask = m; push_addr_arr = a; pop = pp; clear = cl;
        model_step(m, a, pp, cl);
        @(posedge inv_clk); #1;
        push_mask = '0; pop = 1'b0; clear = 1'b0;
        check_model(tag);
    endtask

    typedef struct {
        logic [LN-1:0]    mask;
        logic [LN*AW-1:0] addrs;
        logic             pp;
        logic             cl;
        int               cnt;
        int               top;
        int               done;
        int               udf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{8'b1000_0101, 32'hA000_0703, 1'b0, 1'b0, 3, 'hA, 0, 0};
        tbl[1] = '{8'h00,        32'h0,         1'b1, 1'b0, 2, 'h7, 0, 0};
        tbl[2] = '{8'h00,        32'h0,         1'b1, 1'b0, 1, 'h3, 0, 0};
        tbl[3] = '{8'b0000_0010, 32'h0000_0050, 1'b1, 1'b0, 1, 'h5, 0, 0};
        tbl[4] = '{8'h00,        32'h0,         1'b1, 1'b0, 0, 'h0, 1, 0};
        tbl[5] = '{8'h00,        32'h0,         1'b0, 1'b0, 0, 'h0, 0, 0};
        tbl[6] = '{8'h00,        32'h0,         1'b1, 1'b0, 0, 'h0, 0, 1};
        tbl[7] = '{8'h00,        32'h0,         1'b0, 1'b1, 0, 'h0, 0, 0};

        reset_n = 1'b0; clear = 1'b0; pop = 1'b0;
        push_mask = '0; push_addr_arr = '0;
        model_reset();
        repeat (2) @(posedge inv_clk);
        #1;
        check_model("reset");
        reset_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            push_mask = tbl[v].mask; push_addr_arr = tbl[v].addrs;
            pop = tbl[v].pp; clear = tbl[v].cl;
            model_step(tbl[v].mask, tbl[v].addrs, tbl[v].pp, tbl[v].cl);
            @(posedge inv_clk); #1;
            push_mask = '0; pop = 1'b0; clear = 1'b0;
            check($sformatf("tbl%0d.count", v),     int'(count),       tbl[v].cnt);
            check($sformatf("tbl%0d.top_addr", v),  int'(top_addr),    tbl[v].top);
            check($sformatf("tbl%0d.top_valid", v), int'(top_valid),   (tbl[v].cnt != 0) ? 1 : 0);
            check($sformatf("tbl%0d.done", v),      int'(region_done), tbl[v].done);
            check($sformatf("tbl%0d.underflow", v), int'(underflow),   tbl[v].udf);
        end

        // Overflow: fill to 14, drop a 3-lane batch, then a pop + 4-lane batch
        cyc(8'hFF, 32'h7654_3210, 1'b0, 1'b0, "fill8");
        cyc(8'h3F, 32'h00DC_BA98, 1'b0, 1'b0, "fill14");
        check("fill14.const", int'(count), 14);
        cyc(8'h07, 32'h0000_0EEE, 1'b0, 1'b0, "ovf_push");
        check("ovf_push.count_const", int'(count), 14);
        check("ovf_push.ovf_const", int'(overflow), 1);
        cyc(8'h00, 32'h0, 1'b0, 1'b1, "clear1");
        check("clear1.ovf_const", int'(overflow), 0);
        cyc(8'hFF, 32'h7654_3210, 1'b0, 1'b0, "refill8");
        cyc(8'h3F, 32'h00DC_BA98, 1'b0, 1'b0, "refill14");
        cyc(8'h0F, 32'h0000_1111, 1'b1, 1'b0, "ovf_pop");
        check("ovf_pop.count_const", int'(count), 13);
        check("ovf_pop.top_const", int'(top_addr), 'hC);
        cyc(8'h07, 32'h0000_0321, 1'b0, 1'b0, "to_full");
        check("to_full.full_const", int'(full), 1);
        cyc(8'h01, 32'h0000_0005, 1'b1, 1'b0, "full_swap");
        check("full_swap.count_const", int'(count), 16);
        check("full_swap.top_const", int'(top_addr), 5);
        cyc(8'h03, 32'h0000_0066, 1'b1, 1'b0, "full_pop2");
        check("full_pop2.count_const", int'(count), 15);
        check("full_pop2.top_const", int'(top_addr), 2);

        // Async reset mid-run with 5 entries and a sticky underflow pending
        cyc(8'h00, 32'h0, 1'b0, 1'b1, "clear2");
        cyc(8'h1F, 32'h000A_BCDE, 1'b1, 1'b0, "udf_push5");
        check("udf_push5.udf_const", int'(underflow), 1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        @(posedge inv_clk); #1;
        check_model("reset_hold");
        reset_n = 1'b1;

`ifdef EDA_STACK_HWM_EN
        cyc(8'h3F, 32'h0065_4321, 1'b0, 1'b0, "hwm_push6");
        repeat (4) cyc(8'h00, 32'h0, 1'b1, 1'b0, "hwm_pop");
        cyc(8'h01, 32'h0000_0009, 1'b0, 1'b0, "hwm_push1");
        cyc(8'h00, 32'h0, 1'b0, 1'b0, "hwm_idle");
        check("hwm6.const", int'(hwm), 6);
        cyc(8'h00, 32'h0, 1'b0, 1'b1, "hwm_clear");
        check("hwm_clear.const", int'(hwm), 0);
`endif

        // Random traffic against the queue model
        for (int t = 0; t < 400; t++) begin
            logic [LN-1:0]    rm;
            logic [LN*AW-1:0] ra;
            logic             rp, rc;
            rm = LN'($urandom & $urandom & $urandom);
            ra = ($urandom);
            rp = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 39) == 0);
            cyc(rm, ra, rp, rc, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
